// File: rtl/game_timer_mmss.sv
// game_timer_mmss: BCD mm:ss up/down game timer with pause, preload, sticky down-count expiry,
// a one-cycle tick per digit step and a display snapshot that freezes while the VGA renderer is busy.
// Optional low-time warning output is built only when the macro TIMER_WARN_EN is defined.
module game_timer_mmss #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter bit SATURATE    = 1'b0
`ifdef TIMER_WARN_EN
    ,
    parameter int WARN_SEC    = 10
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_run,
    input  logic       i_mode_down,
    input  logic       i_load,
    input  logic [2:0] i_load_min_ten,
    input  logic [3:0] i_load_min_one,
    input  logic [2:0] i_load_sec_ten,
    input  logic [3:0] i_load_sec_one,
    input  logic       i_VGA_buzy,
    output logic [2:0] o_min_ten,
    output logic [3:0] o_min_one,
    output logic [2:0] o_sec_ten,
    output logic [3:0] o_sec_one,
    output logic       o_tick,
    output logic       o_expired,
    output logic       o_warn
);

    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_HZ - 1);

    function automatic logic [2:0] clamp_ten(input logic [2:0] v);
        if (v > 3'd5) begin
            clamp_ten = 3'd5;
        end else begin
            clamp_ten = v;
        end
    endfunction

    function automatic logic [3:0] clamp_one(input logic [3:0] v);
        if (v > 4'd9) begin
            clamp_one = 4'd9;
        end else begin
            clamp_one = v;
        end
    endfunction

    logic [2:0]    min_ten_r, sec_ten_r;
    logic [3:0]    min_one_r, sec_one_r;
    logic [PW-1:0] presc_r;
    logic          expired_r;
    logic          tick_r;
    logic [2:0]    snap_min_ten_r, snap_sec_ten_r;
    logic [3:0]    snap_min_one_r, snap_sec_one_r;

    logic [2:0]    up_min_ten_s, up_sec_ten_s, dn_min_ten_s, dn_sec_ten_s;
    logic [3:0]    up_min_one_s, up_sec_one_s, dn_min_one_s, dn_sec_one_s;
    logic [2:0]    min_ten_nxt_s, sec_ten_nxt_s;
    logic [3:0]    min_one_nxt_s, sec_one_nxt_s;
    logic [PW-1:0] presc_nxt_s;
    logic          expired_nxt_s;
    logic          tick_nxt_s;
    logic          at_zero_s, at_max_s, dn_zero_s;
    logic          stop_s, count_en_s;

    // Status decode: 00:00 / 59:59 detection and the conditions that freeze the count
    always_comb begin
        at_zero_s  = (min_ten_r == 3'd0) && (min_one_r == 4'd0) &&
                     (sec_ten_r == 3'd0) && (sec_one_r == 4'd0);
        at_max_s   = (min_ten_r == 3'd5) && (min_one_r == 4'd9) &&
                     (sec_ten_r == 3'd5) && (sec_one_r == 4'd9);
        stop_s     = (i_mode_down && expired_r) || (SATURATE && !i_mode_down && at_max_s);
        count_en_s = i_run && !stop_s;
    end

    // Up step: ripple carry sec_one -> sec_ten -> min_one -> min_ten, 59:59 wraps to 00:00
    always_comb begin
        up_min_ten_s = min_ten_r;
        up_min_one_s = min_one_r;
        up_sec_ten_s = sec_ten_r;
        up_sec_one_s = sec_one_r;
        if (sec_one_r < 4'd9) begin
            up_sec_one_s = sec_one_r + 4'd1;
        end else begin
            up_sec_one_s = 4'd0;
            if (sec_ten_r < 3'd5) begin
                up_sec_ten_s = sec_ten_r + 3'd1;
            end else begin
                up_sec_ten_s = 3'd0;
                if (min_one_r < 4'd9) begin
                    up_min_one_s = min_one_r + 4'd1;
                end else begin
                    up_min_one_s = 4'd0;
                    if (min_ten_r < 3'd5) begin
                        up_min_ten_s = min_ten_r + 3'd1;
                    end else begin
                        up_min_ten_s = 3'd0;
                    end
                end
            end
        end
    end

    // Down step: borrows mirror the up carries; only applied when not already at 00:00
    always_comb begin
        dn_min_ten_s = min_ten_r;
        dn_min_one_s = min_one_r;
        dn_sec_ten_s = sec_ten_r;
        dn_sec_one_s = sec_one_r;
        if (sec_one_r != 4'd0) begin
            dn_sec_one_s = sec_one_r - 4'd1;
        end else begin
            dn_sec_one_s = 4'd9;
            if (sec_ten_r != 3'd0) begin
                dn_sec_ten_s = sec_ten_r - 3'd1;
            end else begin
                dn_sec_ten_s = 3'd5;
                if (min_one_r != 4'd0) begin
                    dn_min_one_s = min_one_r - 4'd1;
                end else begin
                    dn_min_one_s = 4'd9;
                    if (min_ten_r != 3'd0) begin
                        dn_min_ten_s = min_ten_r - 3'd1;
                    end else begin
                        dn_min_ten_s = 3'd5;
                    end
                end
            end
        end
        dn_zero_s = (dn_min_ten_s == 3'd0) && (dn_min_one_s == 4'd0) &&
                    (dn_sec_ten_s == 3'd0) && (dn_sec_one_s == 4'd0);
    end

    // Next-state selection with priority clear > load > counting
    always_comb begin
        min_ten_nxt_s = min_ten_r;
        min_one_nxt_s = min_one_r;
        sec_ten_nxt_s = sec_ten_r;
        sec_one_nxt_s = sec_one_r;
        presc_nxt_s   = presc_r;
        expired_nxt_s = expired_r;
        tick_nxt_s    = 1'b0;
        if (i_clear) begin
            min_ten_nxt_s = 3'd0;
            min_one_nxt_s = 4'd0;
            sec_ten_nxt_s = 3'd0;
            sec_one_nxt_s = 4'd0;
            presc_nxt_s   = '0;
            expired_nxt_s = 1'b0;
        end else if (i_load) begin
            min_ten_nxt_s = clamp_ten(i_load_min_ten);
            min_one_nxt_s = clamp_one(i_load_min_one);
            sec_ten_nxt_s = clamp_ten(i_load_sec_ten);
            sec_one_nxt_s = clamp_one(i_load_sec_one);
            presc_nxt_s   = '0;
            expired_nxt_s = 1'b0;
        end else if (count_en_s) begin
            if (presc_r == PRESC_LAST) begin
                presc_nxt_s = '0;
                tick_nxt_s  = 1'b1;
                if (i_mode_down) begin
                    // Reaching 00:00 (or stepping while parked there) expires in the same edge
                    if (at_zero_s) begin
                        expired_nxt_s = 1'b1;
                    end else begin
                        min_ten_nxt_s = dn_min_ten_s;
                        min_one_nxt_s = dn_min_one_s;
                        sec_ten_nxt_s = dn_sec_ten_s;
                        sec_one_nxt_s = dn_sec_one_s;
                        expired_nxt_s = dn_zero_s;
                    end
                end else begin
                    min_ten_nxt_s = up_min_ten_s;
                    min_one_nxt_s = up_min_one_s;
                    sec_ten_nxt_s = up_sec_ten_s;
                    sec_one_nxt_s = up_sec_one_s;
                end
            end else begin
                presc_nxt_s = presc_r + PW'(1);
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Counter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_ten_r <= 3'd0;
            min_one_r <= 4'd0;
            sec_ten_r <= 3'd0;
            sec_one_r <= 4'd0;
            presc_r   <= '0;
            expired_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            min_ten_r <= min_ten_nxt_s;
            min_one_r <= min_one_nxt_s;
            sec_ten_r <= sec_ten_nxt_s;
            sec_one_r <= sec_one_nxt_s;
            presc_r   <= presc_nxt_s;
            expired_r <= expired_nxt_s;
            tick_r    <= tick_nxt_s;
        end
    end

    // Display snapshot: follows the digits unless the renderer is mid-frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_min_ten_r <= 3'd0;
            snap_min_one_r <= 4'd0;
            snap_sec_ten_r <= 3'd0;
            snap_sec_one_r <= 4'd0;
        end else if (!i_VGA_buzy) begin
            snap_min_ten_r <= min_ten_r;
            snap_min_one_r <= min_one_r;
            snap_sec_ten_r <= sec_ten_r;
            snap_sec_one_r <= sec_one_r;
        end else begin
            snap_min_ten_r <= snap_min_ten_r;
            snap_min_one_r <= snap_min_one_r;
            snap_sec_ten_r <= snap_sec_ten_r;
            snap_sec_one_r <= snap_sec_one_r;
        end
    end

`ifdef TIMER_WARN_EN
    localparam logic [11:0] WARN_LIM = 12'(WARN_SEC);

    logic [11:0] remain_s;
    logic        warn_nxt_s;
    logic        warn_r;

    // Warning is derived from next-state values so it lines up with the registered digits
    always_comb begin
        remain_s   = (12'(min_ten_nxt_s) * 12'd600) + (12'(min_one_nxt_s) * 12'd60) +
                     (12'(sec_ten_nxt_s) * 12'd10) + 12'(sec_one_nxt_s);
        warn_nxt_s = i_mode_down && !expired_nxt_s &&
                     (remain_s >= 12'd1) && (remain_s <= WARN_LIM);
    end

    // Warning register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warn_r <= 1'b0;
        end else begin
            warn_r <= warn_nxt_s;
        end
    end

    assign o_warn = warn_r;
`else
    assign o_warn = 1'b0;
`endif

    assign o_min_ten = snap_min_ten_r;
    assign o_min_one = snap_min_one_r;
    assign o_sec_ten = snap_sec_ten_r;
    assign o_sec_one = snap_sec_one_r;
    assign o_tick    = tick_r;
    assign o_expired = expired_r;

endmodule
